// File: rtl/prbs7_checker.sv
// prbs7_checker: PRBS7 (x^7+x^6+1, XNOR feedback) receive checker with hunt/lock FSM and error counting.
// Optional feature macro: PRBS7_CHECKER_BITCNT_EN adds the 32-bit bit_count output.
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   din_valid  qualifies din; din is ignored while low
//   din        received serial bit
//   clr        synchronous clear of err_count (and bit_count); lock state untouched
//   locked     high while in the LOCKED state
//   err_pulse  one-cycle pulse per bit error detected while locked
//   err_count  saturating count of bit errors
//   bit_count  saturating count of valid bits received while locked (macro builds only)
module prbs7_checker #(
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 16,
    parameter int WINDOW   = 64,
    parameter int LOSS_CNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS7_CHECKER_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);
    typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;
    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [9:0] WIN_LAST = 10'(WINDOW - 1);
    localparam logic [9:0] LOSS_N   = 10'(LOSS_CNT);
    state_t     r_state, w_state_nxt;
    logic [6:0] r_sr, w_sr_nxt;
    logic [2:0] r_fill, w_fill_nxt;
    logic [7:0] r_match, w_match_nxt;
    logic [9:0] r_win, w_win_nxt;
    logic [9:0] r_win_err, w_win_err_nxt;
    logic       w_exp, w_hit, w_err;
    assign w_exp  = ~(r_sr[6] ^ r_sr[5]);
    assign w_hit  = (din == w_exp);
    assign locked = (r_state == S_LOCKED);
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_nxt     = r_win;
        w_win_err_nxt = r_win_err;
        w_err         = 1'b0;
        if (din_valid) begin
            if (r_state == S_HUNT) begin
                w_sr_nxt = {r_sr[5:0], din};
                if (r_fill != 3'd7) begin
                    w_fill_nxt = r_fill + 3'd1;
                // 7'h7F is the XNOR lock-up state: a "match" there proves nothing
                end else if (w_hit && r_sr != 7'h7F) begin
                    w_match_nxt = r_match + 8'd1;
                    if (r_match + 8'd1 == LOCK_N) begin
                        w_state_nxt   = S_LOCKED;
                        w_match_nxt   = '0;
                        w_win_nxt     = '0;
                        w_win_err_nxt = '0;
                    end
                end else begin
                    w_match_nxt = '0;
                end
            end else begin
                // free-run on the predicted bit so one bad bit cannot derail the reference
                w_sr_nxt = {r_sr[5:0], w_exp};
                w_err    = ~w_hit;
                if (w_err && (r_win_err + 10'd1) == LOSS_N) begin
                    w_state_nxt   = S_HUNT;
                    w_fill_nxt    = '0;
                    w_match_nxt   = '0;
                    w_win_nxt     = '0;
                    w_win_err_nxt = '0;
                end else if (r_win == WIN_LAST) begin
                    w_win_nxt     = '0;
                    w_win_err_nxt = '0;
                end else begin
                    w_win_nxt     = r_win + 10'd1;
                    w_win_err_nxt = r_win_err + {9'd0, w_err};
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HUNT;
            r_sr      <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win     <= '0;
            r_win_err <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_win     <= w_win_nxt;
            r_win_err <= w_win_err_nxt;
            err_pulse <= w_err;
            if (clr)
                err_count <= '0;
            else if (w_err && err_count != '1)
                err_count <= err_count + ERR_W'(1);
        end
    end
`ifdef PRBS7_CHECKER_BITCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_count <= '0;
        else if (clr)
            bit_count <= '0;
        else if (din_valid && r_state == S_LOCKED && bit_count != '1)
            bit_count <= bit_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: phase-table plus hand sequences for prbs7_checker, scoreboard-checked every cycle.
module tb_prbs7_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
`ifdef PRBS7_CHECKER_BITCNT_EN
    logic [31:0] bit_count, bit_count4;
`endif

    prbs7_checker dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS7_CHECKER_BITCNT_EN
        , .bit_count(bit_count)
`endif
    );

    prbs7_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
`ifdef PRBS7_CHECKER_BITCNT_EN
        , .bit_count(bit_count4)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     lk;
        bit     pl;
        int     c16;
        int     c4;
        longint bc;
    } exp_t;

    typedef struct {
        int n;
        bit gap;
        int off;
        int sp;
        int num;
        bit lk;
        int cnt;
    } ph_t;

    exp_t     sb[$];
    ph_t      ph[5];
    int       n_chk = 0;
    int       n_pass = 0;
    bit [6:0] g_sr;
    bit       m_locked;
    int       m_run, m_win, m_werr, m_cnt;
    longint   m_bits;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #3;
        check("rst locked", locked, 0);
        check("rst err_pulse", err_pulse, 0);
        check("rst err_count", err_count, 0);
        check("rst err_count4", err_count4, 0);
`ifdef PRBS7_CHECKER_BITCNT_EN
        check("rst bit_count", bit_count, 0);
`endif
        rst = 1'b0;
        g_sr = '0;
        m_locked = 0;
        m_run = 0;
        m_win = 0;
        m_werr = 0;
        m_cnt = 0;
        m_bits = 0;
    endtask

    // one clock: drive, predict, then compare after the edge
    task automatic step(input bit v, input bit inj, input bit c, input bit ones);
        exp_t e;
        bit   gb, was_locked;
        gb = ~(g_sr[6] ^ g_sr[5]);
        din_valid = v;
        clr = c;
        din = !v ? 1'($urandom) : (ones ? 1'b1 : (gb ^ inj));
        if (v && !ones) g_sr = {g_sr[5:0], gb};
        was_locked = m_locked;
        e.pl = 0;
        if (v && !m_locked) begin
            if (!ones) m_run++;
            if (m_run == 23) begin
                m_locked = 1;
                m_win = 0;
                m_werr = 0;
            end
        end else if (v) begin
            if (inj) begin
                e.pl = 1;
                m_cnt++;
                m_werr++;
            end
            if (inj && m_werr == 8) begin
                m_locked = 0;
                m_run = 0;
            end else begin
                m_win++;
                if (m_win == 64) begin
                    m_win = 0;
                    m_werr = 0;
                end
            end
        end
        if (v && was_locked) m_bits++;
        if (c) begin
            m_cnt = 0;
            m_bits = 0;
        end
        e.lk = m_locked;
        e.c16 = m_cnt;
        e.c4 = m_cnt > 15 ? 15 : m_cnt;
        e.bc = m_bits;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("locked", locked, e.lk);
        check("err_pulse", err_pulse, e.pl);
        check("err_count", err_count, e.c16);
        check("locked4", locked4, e.lk);
        check("err_pulse4", err_pulse4, e.pl);
        check("err_count4", err_count4, e.c4);
`ifdef PRBS7_CHECKER_BITCNT_EN
        check("bit_count", bit_count, e.bc);
        check("bit_count4", bit_count4, e.bc);
`endif
    endtask

    initial begin
        ph[0] = '{200, 0, 0, 1, 0, 1, 0};
        ph[1] = '{79, 0, 5, 20, 3, 1, 3};
        ph[2] = '{10, 0, 2, 1, 8, 0, 11};
        ph[3] = '{23, 0, 0, 1, 0, 1, 11};
        ph[4] = '{200, 1, 5, 10, 20, 1, 31};
        #1;
        do_reset();
        for (int i = 0; i < 500; i++) step(1, 0, 0, 1);
        check("ones locked", locked, 0);
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < ph[p].n; i++) begin
                int k;
                bit inj;
                k = i - ph[p].off;
                inj = ph[p].num > 0 && k >= 0 && k % ph[p].sp == 0 && k / ph[p].sp < ph[p].num;
                if (ph[p].gap) step(0, 0, 0, 0);
                step(1, inj, 0, 0);
            end
            check($sformatf("phase%0d locked", p), locked, ph[p].lk);
            check($sformatf("phase%0d err_count", p), err_count, ph[p].cnt);
            check($sformatf("phase%0d err_count4", p), err_count4, ph[p].cnt > 15 ? 15 : ph[p].cnt);
        end
        step(1, 0, 1, 0);
        check("clr err_count", err_count, 0);
        check("clr err_count4", err_count4, 0);
        step(1, 1, 0, 0);
        check("err after clr", err_count, 1);
        step(1, 1, 1, 0);
        check("clr+err pulse", err_pulse, 1);
        check("clr+err count", err_count, 0);
        check("clr+err locked", locked, 1);
        step(1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 22; i++) step(1, 0, 0, 0);
        check("relock 22 bits", locked, 0);
        step(1, 0, 0, 0);
        check("relock 23 bits", locked, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 Parameter: ERR_W, 16, width of the error counter.
REQ-002 Parameter: LOCK_CNT, 16, consecutive matching bits needed to lock (2..255).
REQ-003 Parameter: WINDOW, 64, bits per loss-of-lock observation window (8..1023).
REQ-004 Parameter: LOSS_CNT, 8, errors within one window that force loss of lock (1..WINDOW).
REQ-005 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-006 Port: rst  in  1  reset; asynchronous, active-high.
REQ-007 Port: din_valid  in  1  qualifies din; the block ignores din when low.
REQ-008 Port: din  in  1  received serial bit.
REQ-009 Port: clr  in  1  synchronous clear of the counters; does not affect lock state.
REQ-010 Port: locked  out  1  high while in the LOCKED state.
REQ-011 Port: err_pulse  out  1  one-cycle pulse per bit error detected while LOCKED.
REQ-012 Port: err_count  out  ERR_W  saturating count of bit errors.

Function
REQ-013 The checker receives the PRBS7 sequence x^7+x^6+1 with XNOR feedback; the expected bit is sr[6] XNOR sr[5] of the 7-bit shift register sr, and sr shifts left one bit per valid input.
REQ-014 The state machine has two states, HUNT and LOCKED; reset and loss of lock enter HUNT.
REQ-015 HUNT: on each valid bit, din shifts into sr and a fill counter (0..7) increments, saturating at 7.
REQ-016 HUNT: once fill = 7, each valid bit is compared with the expected bit; a match increments the match counter and a mismatch clears it.
REQ-017 HUNT: while sr = 7'h7F (the XNOR lock-up state), a match is treated as a mismatch, so an all-ones stream never locks.
REQ-018 HUNT -> LOCKED on the valid bit that brings the match counter to LOCK_CNT; locked rises in the following cycle.
REQ-019 LOCKED: sr shifts in the expected bit (free-running), not din; din is only compared.
REQ-020 LOCKED: on a mismatch, err_pulse is high in the cycle after the bit is sampled, and err_count increments, holding at 2^ERR_W-1.
REQ-021 LOCKED: a window counter counts valid bits and a window error counter counts mismatches; both clear when WINDOW bits have elapsed.
REQ-022 LOCKED -> HUNT when the window error counter reaches LOSS_CNT.
  - Loss of lock clears the fill, match and window counters.
  - locked falls in the following cycle.
  - err_count is retained.
REQ-023 No state changes when din_valid = 0; err_pulse = 0 in the cycle after an invalid bit.
REQ-024 clr = 1 zeroes err_count (and bit_count when present) at the next edge.
  - clr with a simultaneous error: clr wins and the count reads 0.
  - err_pulse still fires.
REQ-025 Every output is registered; there is no combinational path from input to output.

Reset
REQ-026 Assertion of rst immediately forces the following, regardless of clk:
  - state = HUNT, sr = 0, all internal counters = 0;
  - locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
REQ-027 Reset mid-lock discards lock, and the first valid bit after deassertion is treated as fill bit 1.

Configuration
REQ-028 With macro PRBS7_CHECKER_BITCNT_EN defined, the block adds output bit_count (32 bits).
  - bit_count counts valid bits while LOCKED and saturates at 32'hFFFFFFFF.
  - It is cleared by clr and rst.
REQ-029 Without PRBS7_CHECKER_BITCNT_EN, the bit_count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-030 Clean lock: reset, then a PRBS7 XNOR stream from seed 0 for 200 valid bits -> locked rises after 7+16 valid bits, err_count = 0, err_pulse never high.
REQ-031 Single error: while locked, invert 3 bits spaced 20 apart -> three one-cycle err_pulse, err_count = 3, locked stays 1.
REQ-032 Loss of lock: while locked, invert 8 consecutive bits -> locked falls after the 8th error, err_count = 8, then relocks 23 bits after clean data resumes.
REQ-033 Lock-up immunity: 500 valid bits of constant 1 -> locked stays 0.
REQ-034 Gaps and saturation: ERR_W = 4 with din_valid toggling every cycle and 20 errors injected.
  - err_count holds at 15.
  - err_pulse occurs only after valid bits.
  - clr returns err_count to 0.
REQ-035 Async reset while locked: pulse rst between clock edges -> outputs clear immediately and relock occurs after 23 valid bits.
